// File: rtl/factorial_ctrl_if.sv
// -----------------------------------------------------------------------------
// factorial_ctrl_if
// Bundles the job handshake, the datapath control/status wires and the result
// handshake of the factorial controller.
//
// Handshakes:
//   request : a job is accepted on a rising edge where start && in_ready.
//             n_in is sampled on that edge only.
//   result  : result/ovf/err are valid while out_valid is high; they are
//             consumed on a rising edge where out_valid && out_ack.
//
// Signals:
//   start, n_in        job request and operand N          (master -> ctrl)
//   in_ready           controller idle, can accept         (ctrl -> master)
//   z, a               datapath b==0 flag, a register      (datapath -> ctrl)
//   n_out              latched N for the datapath          (ctrl -> datapath)
//   waSel, wbSel       datapath mux selects                (ctrl -> datapath)
//   result, ovf, err   job outcome                         (ctrl -> master)
//   out_valid, out_ack result handshake
//   dbg_state          controller state encoding, for observation only
//
// Modports: slave = the controller, master = the surrounding system.
// -----------------------------------------------------------------------------
interface factorial_ctrl_if;
    logic        start;
    logic [31:0] n_in;
    logic        in_ready;
    logic        z;
    logic [31:0] a;
    logic [31:0] n_out;
    logic [1:0]  waSel;
    logic [1:0]  wbSel;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ack;
    logic        ovf;
    logic        err;
    logic [2:0]  dbg_state;

    modport slave (
        input  start, n_in, z, a, out_ack,
        output in_ready, n_out, waSel, wbSel, result, out_valid, ovf, err,
               dbg_state
    );

    modport master (
        output start, n_in, z, a, out_ack,
        input  in_ready, n_out, waSel, wbSel, result, out_valid, ovf, err,
               dbg_state
    );
endinterface

// File: rtl/factorial_ctrl.sv
// -----------------------------------------------------------------------------
// factorial_ctrl
// Control FSM for the factorial datapath (a/b register pair with waSel/wbSel
// muxes). Accepts N, sequences load / check / multiply steps until the
// datapath reports b==0, then captures a as the result and holds it on a
// valid/ack handshake. N above MAX_N is rejected with ovf; a job that runs
// TIMEOUT multiply iterations without b reaching zero is aborted with err.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  factorial_ctrl_if.slave (see interface header for signal list)
//
// Parameters:
//   MAX_N    largest N accepted for computation
//   TIMEOUT  multiply iterations before watchdog abort (<= 255)
// -----------------------------------------------------------------------------
module factorial_ctrl #(
    parameter int MAX_N   = 12,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    factorial_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_MULT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] MAX_N_L   = 32'(MAX_N);
    localparam logic [7:0]  TIMEOUT_L = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_n;
    logic [31:0] r_result;
    logic        r_ovf;
    logic        r_err;
    logic [7:0]  r_iter;

    // Control strobes decoded alongside the next-state logic.
    logic w_accept;     // job accepted this edge
    logic w_reject;     // accepted N is out of range
    logic w_cap_ok;     // b reached zero, capture a
    logic w_cap_wd;     // watchdog expired
    logic w_step;       // multiply iteration happening this edge
    logic w_ack;        // result consumed

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_cap_ok     = 1'b0;
        w_cap_wd     = 1'b0;
        w_step       = 1'b0;
        w_ack        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (bus.n_in > MAX_N_L) begin
                        w_reject     = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: w_state_next = S_CHECK;
            S_CHECK: begin
                // z has priority: a job that finishes on the last allowed
                // iteration still returns its result.
                if (bus.z) begin
                    w_cap_ok     = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_iter == TIMEOUT_L) begin
                    w_cap_wd     = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_MULT;
                end
            end
            S_MULT: begin
                w_step       = 1'b1;
                w_state_next = S_CHECK;
            end
            S_DONE: begin
                if (bus.out_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_iter   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_n    <= bus.n_in;
                r_iter <= '0;
                r_ovf  <= w_reject;
                r_err  <= 1'b0;
                if (w_reject) begin
                    r_result <= '0;
                end
            end
            if (w_cap_ok) begin
                r_result <= bus.a;
            end
            if (w_cap_wd) begin
                r_result <= '0;
                r_err    <= 1'b1;
            end
            // Saturate so a huge TIMEOUT can never wrap back to a small count.
            if (w_step && (r_iter != 8'hFF)) begin
                r_iter <= r_iter + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // Moore decode of the datapath selects from the current state.
    always_comb begin
        bus.waSel = 2'b00;
        bus.wbSel = 2'b10;
        unique case (r_state)
            S_LOAD: begin
                bus.waSel = 2'b10;
                bus.wbSel = 2'b00;
            end
            S_MULT: begin
                bus.waSel = 2'b01;
                bus.wbSel = 2'b01;
            end
            default: begin
                bus.waSel = 2'b00;
                bus.wbSel = 2'b10;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.n_out     = r_n;
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;
    assign bus.err       = r_err;
    assign bus.dbg_state = r_state;

    logic w_unused;
    assign w_unused = w_ack;

endmodule

// File: tb/tb_factorial_ctrl.sv
module tb_factorial_ctrl;

  logic clk;
  logic rst;

  factorial_ctrl_if dif ();
  factorial_ctrl_if wif ();

  factorial_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  // Watchdog instance: short TIMEOUT and a datapath that never reports zero.
  factorial_ctrl #(.MAX_N(12), .TIMEOUT(4)) dut_wd (
    .clk (clk),
    .rst (rst),
    .bus (wif.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [33:0] exp_q[$];

  // ---------------------------------------------------------- clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------- datapath model
  logic [31:0] dp_a;
  logic [31:0] dp_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a <= '0;
      dp_b <= '0;
    end else begin
      case (dif.waSel)
        2'b01:   dp_a <= dp_a * dp_b;
        2'b10:   dp_a <= 32'd1;
        default: dp_a <= dp_a;
      endcase
      case (dif.wbSel)
        2'b00:   dp_b <= dif.n_out;
        2'b01:   dp_b <= dp_b - 32'd1;
        default: dp_b <= dp_b;
      endcase
    end
  end

  assign dif.z = (dp_b == 32'd0);
  assign dif.a = dp_a;

  function automatic logic [31:0] fact(input int n);
    logic [31:0] f;
    f = 32'd1;
    for (int i = 2; i <= n; i++) f = f * 32'(i);
    return f;
  endfunction

  // ---------------------------------------------------------- driver tasks
  // Runs one job on the main DUT. Latency counts rising edges from the accept
  // edge (accept edge = 1) until out_valid is seen high.
  task automatic run_job(input logic [31:0] n, input int exp_lat, input bit do_ack);
    int lat;
    logic [33:0] exp_v;
    logic [33:0] got_v;
    @(negedge clk);
    total_cnt++;
    if (dif.in_ready !== 1'b1) $display("FAIL job_ready n=%0d: got %b expected 1", n, dif.in_ready);
    else pass_cnt++;
    dif.start = 1'b1;
    dif.n_in  = n;
    if (n > 32'd12) exp_v = {1'b1, 1'b0, 32'd0};
    else            exp_v = {1'b0, 1'b0, fact(int'(n))};
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.n_in  = $urandom;   // must have no effect after the accept edge
    lat = 1;
    while (dif.out_valid !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total_cnt++;
    if (lat !== exp_lat) $display("FAIL job_latency n=%0d: got %0d expected %0d", n, lat, exp_lat);
    else pass_cnt++;
    got_v = {dif.ovf, dif.err, dif.result};
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL job_scoreboard n=%0d: got output with empty queue, expected none", n);
    end else begin
      exp_v = exp_q.pop_front();
      if (got_v !== exp_v)
        $display("FAIL job_result n=%0d: got ovf/err/result=%h expected %h", n, got_v, exp_v);
      else pass_cnt++;
    end
    total_cnt++;
    if (dif.n_out !== n) $display("FAIL job_n_out: got %0d expected %0d", dif.n_out, n);
    else pass_cnt++;
    if (do_ack) ack_result();
  endtask

  task automatic ack_result();
    @(negedge clk);
    dif.out_ack = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ack = 1'b0;
    total_cnt++;
    if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1)
      $display("FAIL ack_release: got valid=%b ready=%b expected 0/1", dif.out_valid, dif.in_ready);
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------- tests
  task automatic test_reset();
    #1;
    total_cnt++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.result !== 32'd0 ||
        dif.ovf !== 1'b0 || dif.err !== 1'b0 || dif.n_out !== 32'd0 ||
        dif.waSel !== 2'b00 || dif.wbSel !== 2'b10)
      $display("FAIL reset_state: got rdy=%b vld=%b res=%0d ovf=%b err=%b n=%0d sel=%b/%b expected 1/0/0/0/0/0/00/10",
               dif.in_ready, dif.out_valid, dif.result, dif.ovf, dif.err, dif.n_out, dif.waSel, dif.wbSel);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_job();
    int guard;
    @(negedge clk);
    dif.start = 1'b1;
    dif.n_in  = 32'd5;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    guard = 0;
    while (dif.waSel !== 2'b01 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    total_cnt++;
    if (dif.waSel !== 2'b01) $display("FAIL reach_mult: got waSel=%b expected 01", dif.waSel);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.waSel !== 2'b00 || dif.wbSel !== 2'b10)
      $display("FAIL async_reset: got rdy=%b vld=%b sel=%b/%b expected 1/0/00/10",
               dif.in_ready, dif.out_valid, dif.waSel, dif.wbSel);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1)
      $display("FAIL reset_no_result: got vld=%b rdy=%b expected 0/1", dif.out_valid, dif.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_job(32'd5, 13, 1'b1);
  endtask

  task automatic test_bounds();
    run_job(32'd0, 3, 1'b1);
    run_job(32'd1, 5, 1'b1);
    run_job(32'd12, 27, 1'b1);
    total_cnt++;
    if (dif.result !== 32'd479001600) $display("FAIL n12_value: got %0d expected 479001600", dif.result);
    else pass_cnt++;
  endtask

  task automatic test_ovf();
    logic [31:0] a_before;
    logic [31:0] b_before;
    a_before = dp_a;
    b_before = dp_b;
    run_job(32'd13, 1, 1'b0);
    total_cnt++;
    if (dp_a !== a_before || dp_b !== b_before || dif.waSel !== 2'b00 || dif.wbSel !== 2'b10)
      $display("FAIL ovf_untouched: got a=%0d b=%0d sel=%b/%b expected a=%0d b=%0d 00/10",
               dp_a, dp_b, dif.waSel, dif.wbSel, a_before, b_before);
    else pass_cnt++;
    ack_result();
    run_job(32'hFFFF_FFFF, 1, 1'b1);
  endtask

  task automatic test_watchdog();
    int lat;
    @(negedge clk);
    wif.start = 1'b1;
    wif.n_in  = 32'd5;
    @(posedge clk);
    #1;
    wif.start = 1'b0;
    lat = 1;
    while (wif.out_valid !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total_cnt++;
    if (lat !== 11) $display("FAIL wd_latency: got %0d expected 11", lat);
    else pass_cnt++;
    total_cnt++;
    if (wif.err !== 1'b1 || wif.ovf !== 1'b0 || wif.result !== 32'd0)
      $display("FAIL wd_flags: got err=%b ovf=%b res=%0d expected 1/0/0", wif.err, wif.ovf, wif.result);
    else pass_cnt++;
    @(negedge clk);
    wif.out_ack = 1'b1;
    @(posedge clk);
    #1;
    wif.out_ack = 1'b0;
    total_cnt++;
    if (wif.in_ready !== 1'b1 || wif.err !== 1'b1)
      $display("FAIL wd_release: got rdy=%b err=%b expected 1/1", wif.in_ready, wif.err);
    else pass_cnt++;
  endtask

  task automatic test_hold_done();
    int bad;
    // Ack while nothing is pending must be ignored.
    @(negedge clk);
    dif.out_ack = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ack = 1'b0;
    total_cnt++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0)
      $display("FAIL idle_ack: got rdy=%b vld=%b expected 1/0", dif.in_ready, dif.out_valid);
    else pass_cnt++;

    run_job(32'd3, 9, 1'b0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dif.start = (c == 4);
      dif.n_in  = 32'd7;
      if (dif.result !== 32'd6 || dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0 || dif.n_out !== 32'd3)
        bad++;
    end
    @(negedge clk);
    dif.start = 1'b0;
    total_cnt++;
    if (bad != 0 || dif.result !== 32'd6 || dif.n_out !== 32'd3)
      $display("FAIL done_hold: got %0d bad cycles result=%0d n_out=%0d expected 0 bad, 6, 3",
               bad, dif.result, dif.n_out);
    else pass_cnt++;
    ack_result();
    run_job(32'd4, 11, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] n;
    for (int k = 0; k < 8; k++) begin
      n = 32'($urandom_range(0, 14));
      run_job(n, (n > 32'd12) ? 1 : 3 + 2 * int'(n), 1'b1);
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  // ---------------------------------------------------------- main sequence
  initial begin
    rst         = 1'b1;
    dif.start   = 1'b0;
    dif.n_in    = '0;
    dif.out_ack = 1'b0;
    wif.start   = 1'b0;
    wif.n_in    = '0;
    wif.out_ack = 1'b0;
    wif.z       = 1'b0;
    wif.a       = 32'hDEAD_BEEF;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset_mid_job();
    test_basic();
    test_bounds();
    test_ovf();
    test_watchdog();
    test_hold_done();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
